// File: rtl/sw_allocator_if.sv
// ----------------------------------------------------------------------------
// sw_allocator_if
// Purpose : Bundles the switch-allocation request/grant signals between the
//           router input ports, the output ports and the switch allocator.
// Signals :
//   sw_req    [NUM_PORTS]        per input, a flit is ready
//   req_dst   [NUM_PORTS*DST_W]  per input, requested output index
//   req_tail  [NUM_PORTS]        per input, presented flit ends its packet
//   out_ready [NUM_PORTS]        per output, downstream can accept a flit
//   grant     [NUM_PORTS]        per input, flit transferred this cycle
//   xbar_sel  [NUM_PORTS*DST_W]  per output, selected input index
//   xbar_vld  [NUM_PORTS]        per output, crossbar drives a valid flit
//   err_dst                      sticky out-of-range destination flag
// Modports: master drives requests and readiness, slave is the allocator.
// ----------------------------------------------------------------------------
interface sw_allocator_if #(
    parameter int NUM_PORTS = 5,
    parameter int DST_W     = 3
);
    logic [NUM_PORTS-1:0]       sw_req;
    logic [NUM_PORTS*DST_W-1:0] req_dst;
    logic [NUM_PORTS-1:0]       req_tail;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       grant;
    logic [NUM_PORTS*DST_W-1:0] xbar_sel;
    logic [NUM_PORTS-1:0]       xbar_vld;
    logic                       err_dst;

    modport master (
        output sw_req, req_dst, req_tail, out_ready,
        input  grant, xbar_sel, xbar_vld, err_dst
    );

    modport slave (
        input  sw_req, req_dst, req_tail, out_ready,
        output grant, xbar_sel, xbar_vld, err_dst
    );
endinterface

// File: rtl/sw_allocator.sv
// ----------------------------------------------------------------------------
// sw_allocator
// Purpose : Wormhole switch allocator for a NUM_PORTS x NUM_PORTS router.
//           Each output is either IDLE, where it arbitrates round-robin among
//           the inputs requesting it, or LOCKED to the input whose packet it
//           is currently carrying until that packet's tail flit passes.
//           Allocation is combinational (zero-cycle latency); only the lock,
//           owner, round-robin pointer and error flag are registered.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   sw_allocator_if.slave (requests in, grants/crossbar control out)
// ----------------------------------------------------------------------------
module sw_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int DST_W     = 3
) (
    input  logic           clk,
    input  logic           rst,
    sw_allocator_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } out_state_e;

    // Per-output registered state
    out_state_e       state_q [NUM_PORTS];
    out_state_e       state_d [NUM_PORTS];
    logic [DST_W-1:0] owner_q [NUM_PORTS];
    logic [DST_W-1:0] owner_d [NUM_PORTS];
    logic [DST_W-1:0] ptr_q   [NUM_PORTS];
    logic [DST_W-1:0] ptr_d   [NUM_PORTS];
    logic             err_q;
    logic             err_d;

    // Combinational allocation results
    logic [NUM_PORTS-1:0]       grant_w;
    logic [NUM_PORTS*DST_W-1:0] sel_w;
    logic [NUM_PORTS-1:0]       vld_w;

    // Per-output scratch used while walking the outputs
    logic [NUM_PORTS-1:0] elig;
    logic                 found;
    int                   win_idx;
    int                   scan_idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_w  = '0;
        sel_w    = '0;
        vld_w    = '0;
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        elig     = '0;
        found    = 1'b0;
        win_idx  = 0;
        scan_idx = 0;

        // An out-of-range destination never matches any output below, so it
        // is never granted; it only raises the sticky error flag.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.sw_req[i] && (int'(bus.req_dst[i*DST_W +: DST_W]) >= NUM_PORTS)) begin
                err_d = 1'b1;
            end
        end

        if (!rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    elig[i] = bus.sw_req[i] && (bus.req_dst[i*DST_W +: DST_W] == DST_W'(o));
                end
                found   = 1'b0;
                win_idx = 0;

                // Without downstream readiness the output neither grants nor
                // commits to a new owner; its state simply holds.
                if (bus.out_ready[o]) begin
                    if (state_q[o] == ST_LOCKED) begin
                        if (elig[int'(owner_q[o])]) begin
                            found   = 1'b1;
                            win_idx = int'(owner_q[o]);
                        end
                    end else begin
                        for (int k = 0; k < NUM_PORTS; k++) begin
                            scan_idx = int'(ptr_q[o]) + k;
                            if (scan_idx >= NUM_PORTS) begin
                                scan_idx = scan_idx - NUM_PORTS;
                            end
                            if (!found && elig[scan_idx]) begin
                                found   = 1'b1;
                                win_idx = scan_idx;
                            end
                        end
                    end
                end

                if (found) begin
                    // Each input targets one output, so at most one output can
                    // set any given grant bit.
                    grant_w[win_idx]            = 1'b1;
                    vld_w[o]                    = 1'b1;
                    sel_w[o*DST_W +: DST_W]     = DST_W'(win_idx);
                    if (bus.req_tail[win_idx]) begin
                        // Packet done: release and move priority past the winner.
                        state_d[o] = ST_IDLE;
                        ptr_d[o]   = (win_idx == NUM_PORTS - 1) ? '0 : DST_W'(win_idx + 1);
                    end else begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = DST_W'(win_idx);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant    = grant_w;
    assign bus.xbar_sel = sel_w;
    assign bus.xbar_vld = vld_w;
    assign bus.err_dst  = err_q;

endmodule

// File: doc/sw_allocator.md
SW_ALLOCATOR -- requirements
Module: sw_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of router ports (input and output), indices 0..NUM_PORTS-1.
REQ-002 Parameter DST_W, default 3, width of an output-port index; SHALL satisfy 2**DST_W >= NUM_PORTS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw_req  input  NUM_PORTS  per input port, a flit is ready at that port.
REQ-006 req_dst  input  NUM_PORTS*DST_W  per input port, the requested output port index; input i occupies bits [i*DST_W +: DST_W].
REQ-007 req_tail  input  NUM_PORTS  per input port, the presented flit is a tail (or single-flit) packet end.
REQ-008 out_ready  input  NUM_PORTS  per output port, downstream can accept a flit this cycle.
REQ-009 grant  output  NUM_PORTS  per input port, the flit is transferred this cycle; input port pops its FIFO.
REQ-010 xbar_sel  output  NUM_PORTS*DST_W  per output port, the selected input index; output o occupies bits [o*DST_W +: DST_W].
REQ-011 xbar_vld  output  NUM_PORTS  per output port, the crossbar drives a valid flit this cycle.
REQ-012 err_dst  output  1  sticky flag, set when any sw_req is high with req_dst >= NUM_PORTS.

Function
REQ-013 grant, xbar_sel and xbar_vld SHALL be combinational from the current inputs and registered state (zero-cycle allocation latency).
REQ-014 Per output o, eligible set = inputs i with sw_req[i]=1 and req_dst[i]=o.
REQ-015 Output o state SHALL be one of: IDLE (no lock) or LOCKED(owner), owner being an input index.
REQ-016 In IDLE, when out_ready[o]=1, o SHALL pick the first eligible input scanning round-robin from ptr[o] upward with wrap at NUM_PORTS.
REQ-017 In LOCKED(owner), o SHALL grant only the owner, and only when the owner is eligible and out_ready[o]=1; other requesters SHALL receive no grant.
REQ-018 When o grants input w: grant[w]=1, xbar_vld[o]=1, xbar_sel[o]=w; otherwise xbar_vld[o]=0 and xbar_sel[o]=0.
REQ-019 On a granted non-tail flit (req_tail[w]=0), o SHALL enter or remain in LOCKED(w) at the next edge.
REQ-020 On a granted tail flit, o SHALL return to IDLE and ptr[o] SHALL become (w+1) mod NUM_PORTS at the next edge.
REQ-021 ptr[o] SHALL change only per REQ-020; a no-grant cycle leaves lock and ptr unchanged.
REQ-022 With out_ready[o]=0, o SHALL grant nothing and keep its state, including an IDLE-to-LOCKED decision not yet made.
REQ-023 Each input SHALL receive at most one grant per cycle, since it requests exactly one output.
REQ-024 A request with req_dst >= NUM_PORTS SHALL never be granted.
REQ-025 Such a request SHALL set err_dst at the next edge; err_dst stays 1 until reset.
REQ-026 Single-flit packets (head and tail together, req_tail=1 on the first grant) SHALL leave o IDLE, with ptr advanced.

Reset
REQ-027 While rst=1 at an edge: all outputs to IDLE, all ptr to 0, err_dst to 0.
REQ-028 While rst=1, grant, xbar_vld and xbar_sel SHALL be forced to 0.
REQ-029 Reset mid-packet SHALL drop any lock without completing the packet.

Verification
REQ-030 Contention: inputs 1 and 3 request output 2, both tail, ptr[2]=0, out_ready=all 1 -> cycle 0 grant=00010; cycle 1 grant=01000; cycle 2 grant=00010.
REQ-031 Wormhole lock: input 0 sends head+body+tail (req_tail 0,0,1) to output 4 while input 2 also requests 4 -> input 0 granted 3 consecutive cycles, xbar_sel[4]=0; input 2 granted in cycle 3; ptr[4]=1 after the tail.
REQ-032 Backpressure: locked packet, out_ready[4]=0 for 2 cycles -> grant=0 and xbar_vld[4]=0 for those cycles; lock retained; resume on the owner.
REQ-033 Parallel: inputs 0..4 request outputs 4,3,2,1,0 respectively, all tail -> grant=11111 in one cycle; xbar_sel[o]=4-o.
REQ-034 Bad destination: sw_req[1]=1, req_dst[1]=6 (NUM_PORTS=5) -> grant[1]=0 and err_dst=1 next cycle, held until rst.
REQ-035 Reset mid-packet: rst asserted after a head grant to output 2 -> all grants 0 during rst; after release another input's head to output 2 is granted immediately.
